mult_seq_ctrl: RTL
==================

Name: mult_seq_ctrl

Overview:
Memory-mapped controller that sequences an iterative shift-add multiplier on the picorv32 native memory bus. Firmware writes two operands and a start command, polls STATUS or waits for irq, then reads a 2N-bit product over two words. The block sits beside the system memory decode and claims one register window. It replaces direct wiring of operand registers to a combinational multiplier with a fixed-latency, handshaked multi-cycle unit.

Parameters:
N, 32, operand width in bits; product width is 2N; N must be 32 for the bus mapping below.
BASE_ADDR, 32'h0FFF_FFC0, byte address of the register window; 32-byte aligned.

Ports:
clk  input  1  system clock.
resetn  input  1  reset, asynchronous, active-low.
mem_valid  input  1  picorv32 bus request valid.
mem_addr  input  32  byte address.
mem_wdata  input  32  write data.
mem_wstrb  input  4  byte strobes; 0 = read.
sel  output  1  combinational; high when mem_valid and mem_addr[31:5] == BASE_ADDR[31:5].
ctrl_ready  output  1  one-cycle acknowledge for a selected access.
ctrl_rdata  output  32  read data; valid while ctrl_ready is high.
irq  output  1  done AND irq_en.

Behaviour:
- Reset (resetn low, asynchronous): state=IDLE, OPA=0, OPB=0, product=0, cnt=0, done=0, irq_en=0, ctrl_ready=0, ctrl_rdata=0. irq is therefore 0.
- Register map, offsets from BASE_ADDR:
  - 0x00 OPA (RW).
  - 0x04 OPB (RW).
  - 0x08 CTRL (W): bit0 start, bit1 irq_en, bit2 clear_done. Reads return {30'b0, irq_en, 1'b0}.
  - 0x0C STATUS (R): {30'b0, done, busy}.
  - 0x10 RES_LO (R).
  - 0x14 RES_HI (R).
  - 0x18 and 0x1C read 0; writes to them are ignored.
- Handshake:
  - On an edge where sel && !ctrl_ready, ctrl_ready<=1 for exactly one cycle. The next cycle has ctrl_ready=0, so back-to-back accesses are 2 cycles each.
  - ctrl_rdata is registered on that same edge.
  - Writes take effect on that same edge.
- Writes: only mem_wstrb==4'hF updates a register. Partial-strobe writes are acknowledged and discarded.
- Busy lockout: while busy, writes to OPA, OPB and start are acknowledged and ignored. irq_en and clear_done are still honoured.
- FSM, IDLE -> RUN:
  - Triggered by an accepted CTRL write with bit0=1 from IDLE or DONE.
  - On that edge: acc=0, multiplicand=OPA zero-extended to 2N bits, multiplier=OPB, cnt=0, done<=0.
- FSM, RUN:
  - Each edge: if multiplier[0], acc <= acc + multiplicand (2N-bit, no overflow possible).
  - Same edge: multiplicand <<= 1, multiplier >>= 1, cnt <= cnt+1.
  - On the edge where cnt==N-1: state<=DONE, product<=final acc, done<=1.
- FSM, DONE: remains until the next start (-> RUN). A clear_done write sets done=0 and state=IDLE.
- Latency and timing:
  - busy = (state==RUN). busy is high for exactly N cycles after the accepting edge.
  - done rises on the N-th RUN edge. Latency is fixed, independent of operand values, including zero.
- product register: holds the last result until the next completion. A start does not clear RES_LO/RES_HI.
- Simultaneous events:
  - A STATUS read captured on the completion edge returns the pre-edge value {done=0, busy=1}.
  - A CTRL write with start=1 and clear_done=1 together: start wins.
- Arithmetic: unsigned.
  - 0xFFFFFFFF*0xFFFFFFFF = 0xFFFFFFFE_00000001.
- Reset mid-RUN: immediate return to IDLE; all state cleared as above.

Decomposition:
- Shared package: register offset constants (OFS_OPA=0x00 ... OFS_RES_HI=0x14), CTRL/STATUS bit indices, FSM state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2).
- Sub-module shift_add_mult_dp holds the datapath: acc, multiplicand, multiplier, cnt.
  - Inputs: load, step, opa, opb.
  - Outputs: acc, last (cnt==N-1).
- mult_seq_ctrl holds bus decode, registers and FSM.

Test Plan:
- Reset then read all six offsets -> every read returns 0; ctrl_ready pulses 1 cycle per access; irq=0.
- OPA=3, OPB=5, start; poll STATUS -> busy for exactly 32 cycles after the acknowledging edge, then STATUS=0x2; RES_LO=15, RES_HI=0.
- OPA=OPB=0xFFFFFFFF with irq_en=1 -> irq rises on the completion edge; RES_HI=0xFFFFFFFE, RES_LO=0x00000001; clear_done write -> irq=0, STATUS=0.
- During RUN, write OPA=7 and start again -> writes ignored; result equals the original operands' product at the original completion cycle; OPA still reads the old value.
- Partial write (wstrb=4'b0011) to OPB=0x1234 -> acknowledged, OPB unchanged; a write to offset 0x1C is acknowledged and has no effect.
- Assert resetn low 10 cycles into RUN -> STATUS=0, RES_LO=RES_HI=0; a subsequent start runs the full 32 cycles and gives a correct product.

Source files
------------

// File: rtl/mult_seq_ctrl_pkg.sv
// Shared definitions for the sequential multiplier controller:
// register offsets, CTRL/STATUS bit positions and FSM state encoding.
package mult_seq_ctrl_pkg;

  // Byte offsets within the 32-byte register window
  localparam logic [4:0] OFS_OPA    = 5'h00;
  localparam logic [4:0] OFS_OPB    = 5'h04;
  localparam logic [4:0] OFS_CTRL   = 5'h08;
  localparam logic [4:0] OFS_STATUS = 5'h0C;
  localparam logic [4:0] OFS_RES_LO = 5'h10;
  localparam logic [4:0] OFS_RES_HI = 5'h14;

  // CTRL register bits
  localparam int unsigned CTRL_START_BIT    = 0;
  localparam int unsigned CTRL_IRQ_EN_BIT   = 1;
  localparam int unsigned CTRL_CLR_DONE_BIT = 2;

  // STATUS register bits
  localparam int unsigned STATUS_BUSY_BIT = 0;
  localparam int unsigned STATUS_DONE_BIT = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Assemble the STATUS read word
  function automatic logic [31:0] status_word(input logic done, input logic busy);
    logic [31:0] w;
    w = '0;
    w[STATUS_DONE_BIT] = done;
    w[STATUS_BUSY_BIT] = busy;
    return w;
  endfunction

  // Assemble the CTRL read word (only irq_en is readable)
  function automatic logic [31:0] ctrl_word(input logic irq_en);
    logic [31:0] w;
    w = '0;
    w[CTRL_IRQ_EN_BIT] = irq_en;
    return w;
  endfunction

endpackage

// File: rtl/mult_seq_ctrl_dp.sv
// Shift-add multiplier datapath: one partial product per step, N steps per
// product. The acc output is the running sum including the partial product
// of the current step, i.e. the value the accumulator takes on this edge.
module shift_add_mult_dp #(
  parameter int unsigned N = 32
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic           load,
  input  logic           step,
  input  logic [N-1:0]   opa,
  input  logic [N-1:0]   opb,
  output logic [2*N-1:0] acc,
  output logic           last
);

  localparam int unsigned CW = $clog2(N);
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  logic [2*N-1:0] acc_q;
  logic [2*N-1:0] mcand_q;
  logic [N-1:0]   mplier_q;
  logic [CW-1:0]  cnt_q;

  // Exposing the post-step sum lets the controller capture the final
  // product on the same edge that retires the last step.
  assign acc  = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
  assign last = (cnt_q == CNT_LAST);

  // Load operands on start, then shift/accumulate once per step
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else if (load) begin
      acc_q    <= '0;
      mcand_q  <= {{N{1'b0}}, opa};
      mplier_q <= opb;
      cnt_q    <= '0;
    end else if (step) begin
      acc_q    <= acc;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/mult_seq_ctrl.sv
// Memory-mapped controller for the iterative shift-add multiplier on the
// picorv32 native bus: operand/control/status/result registers, a
// single-cycle acknowledge handshake and the IDLE/RUN/DONE sequencer.
module mult_seq_ctrl
  import mult_seq_ctrl_pkg::*;
#(
  parameter int unsigned N         = 32,
  parameter logic [31:0] BASE_ADDR = 32'h0FFF_FFC0
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mem_valid,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        sel,
  output logic        ctrl_ready,
  output logic [31:0] ctrl_rdata,
  output logic        irq
);

  state_t         state;
  logic [N-1:0]   opa_q;
  logic [N-1:0]   opb_q;
  logic [2*N-1:0] product_q;
  logic           done_q;
  logic           irq_en_q;

  logic           accept;
  logic           wr_en;
  logic           wr_ctrl;
  logic           busy;
  logic           start_go;
  logic [4:0]     ofs;
  logic [31:0]    rd_mux;

  logic [2*N-1:0] dp_acc;
  logic           dp_last;

  assign sel      = mem_valid && (mem_addr[31:5] == BASE_ADDR[31:5]);
  assign accept   = sel && !ctrl_ready;
  assign ofs      = mem_addr[4:0];
  assign wr_en    = accept && (mem_wstrb == 4'hF);
  assign wr_ctrl  = wr_en && (ofs == OFS_CTRL);
  assign busy     = (state == ST_RUN);
  assign start_go = wr_ctrl && mem_wdata[CTRL_START_BIT] && !busy;
  assign irq      = done_q && irq_en_q;

  shift_add_mult_dp #(
    .N(N)
  ) u_dp (
    .clk    (clk),
    .resetn (resetn),
    .load   (start_go),
    .step   (busy),
    .opa    (opa_q),
    .opb    (opb_q),
    .acc    (dp_acc),
    .last   (dp_last)
  );

  // Read data selection from pre-edge register state
  always_comb begin
    rd_mux = '0;
    case (ofs)
      OFS_OPA:    rd_mux = opa_q;
      OFS_OPB:    rd_mux = opb_q;
      OFS_CTRL:   rd_mux = ctrl_word(irq_en_q);
      OFS_STATUS: rd_mux = status_word(done_q, busy);
      OFS_RES_LO: rd_mux = product_q[N-1:0];
      OFS_RES_HI: rd_mux = product_q[2*N-1:N];
      default:    rd_mux = '0;
    endcase
  end

  // Bus handshake, register writes and sequencer state
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= ST_IDLE;
      opa_q      <= '0;
      opb_q      <= '0;
      product_q  <= '0;
      done_q     <= 1'b0;
      irq_en_q   <= 1'b0;
      ctrl_ready <= 1'b0;
      ctrl_rdata <= '0;
    end else begin
      ctrl_ready <= accept;
      if (accept) begin
        ctrl_rdata <= rd_mux;
      end

      if (wr_en && !busy) begin
        if (ofs == OFS_OPA) opa_q <= mem_wdata;
        if (ofs == OFS_OPB) opb_q <= mem_wdata;
      end

      if (wr_ctrl) begin
        irq_en_q <= mem_wdata[CTRL_IRQ_EN_BIT];
      end

      case (state)
        ST_IDLE, ST_DONE: begin
          // Start takes priority over clear_done when both are set
          if (start_go) begin
            state  <= ST_RUN;
            done_q <= 1'b0;
          end else if (wr_ctrl && mem_wdata[CTRL_CLR_DONE_BIT]) begin
            state  <= ST_IDLE;
            done_q <= 1'b0;
          end
        end
        ST_RUN: begin
          if (dp_last) begin
            state     <= ST_DONE;
            product_q <= dp_acc;
            done_q    <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
